// File: rtl/array3d_reduce_pkg.sv
// Shared constants, stage bundle type and sizing helpers
// for the pipelined 3-D array reduction.
package array3d_reduce_pkg;

    localparam int DEF_D0    = 2;
    localparam int DEF_D1    = 2;
    localparam int DEF_D2    = 2;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHIFT = 1;

    typedef struct packed {
        logic valid;
        logic last;
    } stage_ctl_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    function automatic int next_pow2(input int n);
        return 1 << clog2(n);
    endfunction

    function automatic int idx(
        input int i,
        input int j,
        input int k,
        input int d1 = DEF_D1,
        input int d2 = DEF_D2
    );
        return (i * d1 + j) * d2 + k;
    endfunction

endpackage

// File: rtl/reduce_tree_level.sv
// One registered pairwise-add level of the reduction tree.
// Sums wrap mod 2^WIDTH; the level holds whenever en is low.
module reduce_tree_level
    import array3d_reduce_pkg::*;
#(
    parameter int IN_COUNT = 2,
    parameter int WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [IN_COUNT*WIDTH-1:0]     in_sum,
    input  stage_ctl_t                    in_ctl,
    output logic [IN_COUNT/2*WIDTH-1:0]   out_sum,
    output stage_ctl_t                    out_ctl
);

    localparam int OUT_COUNT = IN_COUNT / 2;

    logic [OUT_COUNT*WIDTH-1:0] pair_sum;

    always_comb begin
        pair_sum = '0;
        for (int p = 0; p < OUT_COUNT; p++) begin
            pair_sum[p*WIDTH +: WIDTH] =
                in_sum[(2*p)*WIDTH +: WIDTH] +
                in_sum[(2*p+1)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum <= '0;
            out_ctl <= '0;
        end else if (en) begin
            out_sum       <= pair_sum;
            out_ctl.valid <= in_ctl.valid;
            out_ctl.last  <= in_ctl.valid && in_ctl.last;
        end
    end

endmodule

// File: rtl/array3d_reduce_pipe.sv
// Pipelined 3-D array reducer: adder tree, frame accumulator,
// final left shift, valid/ready on both sides with a global stall.
module array3d_reduce_pipe
    import array3d_reduce_pkg::*;
#(
    parameter int D0    = DEF_D0,
    parameter int D1    = DEF_D1,
    parameter int D2    = DEF_D2,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [D0*D1*D2*WIDTH-1:0] in_data,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int N = D0 * D1 * D2;
    localparam int P = next_pow2(N);
    localparam int L = clog2(P);

    logic             en;
    logic [P*WIDTH-1:0] pad;
    stage_ctl_t       in_ctl;
    logic [WIDTH-1:0] head_sum;
    stage_ctl_t       head_ctl;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] shifted;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        pad            = '0;
        pad[N*WIDTH-1:0] = in_data;
    end

    always_comb begin
        in_ctl.valid = in_valid;
        in_ctl.last  = in_last;
    end

    generate
        if (L == 0) begin : g_bypass
            assign head_sum = pad[WIDTH-1:0];
            assign head_ctl = in_ctl;
        end else begin : g_tree
            // Level m output sits at element offset P - (P >> m).
            logic [(P-1)*WIDTH-1:0] bus;
            stage_ctl_t [L:0]       ctl;

            assign ctl[0] = in_ctl;

            for (genvar m = 0; m < L; m++) begin : g_lvl
                localparam int IC  = P >> m;
                localparam int OFS = P - (P >> m);

                if (m == 0) begin : g_root
                    reduce_tree_level #(
                        .IN_COUNT (IC),
                        .WIDTH    (WIDTH)
                    ) u_level (
                        .clk     (clk),
                        .rst_n   (rst_n),
                        .en      (en),
                        .in_sum  (pad),
                        .in_ctl  (ctl[m]),
                        .out_sum (bus[OFS*WIDTH +: IC/2*WIDTH]),
                        .out_ctl (ctl[m+1])
                    );
                end else begin : g_inner
                    localparam int PREV = P - (P >> (m - 1));

                    reduce_tree_level #(
                        .IN_COUNT (IC),
                        .WIDTH    (WIDTH)
                    ) u_level (
                        .clk     (clk),
                        .rst_n   (rst_n),
                        .en      (en),
                        .in_sum  (bus[PREV*WIDTH +: IC*WIDTH]),
                        .in_ctl  (ctl[m]),
                        .out_sum (bus[OFS*WIDTH +: IC/2*WIDTH]),
                        .out_ctl (ctl[m+1])
                    );
                end
            end

            assign head_sum = bus[(P-2)*WIDTH +: WIDTH];
            assign head_ctl = ctl[L];
        end
    endgenerate

    always_comb begin
        sum_s   = acc + head_sum;
        shifted = sum_s << SHIFT;
    end

    // A closing beat clears acc, so the next beat starts a fresh frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            if (head_ctl.valid) begin
                if (head_ctl.last) begin
                    out_data  <= shifted;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc       <= sum_s;
                    out_valid <= 1'b0;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    a_hold : assert property (
        @(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out_data)
    );

endmodule

// File: tb/tb_array3d_reduce_pipe.sv
// Directed bench: frame-sum model plus literal checks on the
// default-sized block and a 3x1x1 byte-wide instance.
module tb_array3d_reduce_pipe;
    import array3d_reduce_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] in_data;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;

    logic [23:0]  s_in_data;
    logic         s_in_last;
    logic         s_in_valid;
    logic         s_in_ready;
    logic [7:0]   s_out_data;
    logic         s_out_valid;
    logic         s_out_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] acc_m;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_v;
    logic        stalled_q = 1'b0;
    logic [31:0] held;

    always #5 clk = ~clk;

    array3d_reduce_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    array3d_reduce_pipe #(
        .D0(3), .D1(1), .D2(1), .WIDTH(8), .SHIFT(0)
    ) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (s_in_data),
        .in_last   (s_in_last),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [31:0] v);
        logic [255:0] d;
        for (int e = 0; e < 8; e++) d[e*32 +: 32] = v;
        return d;
    endfunction

    function automatic logic [255:0] seq_data();
        logic [255:0] d;
        int f;
        d = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++) begin
                    f = idx(i, j, k, 2, 2);
                    d[f*32 +: 32] = 32'(f + 1);
                end
        return d;
    endfunction

    // Frame model: add every element of every accepted beat, emit on last.
    task automatic model_accept(input logic [255:0] d, input logic last);
        for (int e = 0; e < 8; e++) acc_m = acc_m + d[e*32 +: 32];
        if (last) begin
            exp_q.push_back(acc_m << 1);
            acc_m = '0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [255:0] d, input logic last);
        int g;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        model_accept(d, last);
        @(posedge clk); #1;
    endtask

    task automatic wait_out(input int exp_lat, input string name);
        int lat;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_q = 1'b0;
        end else begin
            if (stalled_q) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got 0x%08h expected none",
                             out_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("model_out", out_data, exp_v);
                    got_q.push_back(out_data);
                end
            end
            stalled_q = out_valid && !out_ready;
            held      = out_data;
        end
    end

    initial begin
        int g;
        int lat;
        rst_n       = 1'b1;
        in_data     = '0;
        in_last     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        s_in_data   = '0;
        s_in_last   = 1'b0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        acc_m       = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_s_valid", 32'(s_out_valid), 32'd0);
        rst_n = 1'b1;
        step();

        send(seq_data(), 1'b1);
        in_valid = 1'b0;
        wait_out(4, "t1");
        check("t1_data", out_data, 32'd72);
        step();
        check("t1_pulse", 32'(out_valid), 32'd0);

        send(fill(32'h8000_0001), 1'b1);
        in_valid = 1'b0;
        wait_out(4, "t2");
        check("t2_data", out_data, 32'h0000_0010);
        step();

        send(fill(32'd1), 1'b0);
        send(fill(32'd1), 1'b0);
        send(fill(32'd1), 1'b1);
        in_valid = 1'b0;
        wait_out(4, "t3");
        check("t3_data", out_data, 32'd48);
        step();
        send(fill(32'd1), 1'b1);
        in_valid = 1'b0;
        wait_out(4, "t3b");
        check("t3b_data", out_data, 32'd16);
        step();

        got_q.delete();
        out_ready = 1'b0;
        send(seq_data(), 1'b1);
        send(fill(32'd1), 1'b1);
        send(fill(32'd2), 1'b1);
        in_valid = 1'b0;
        wait_out(2, "t4");
        for (int c = 0; c < 5; c++) begin
            check("t4_in_ready", 32'(in_ready), 32'd0);
            check("t4_data", out_data, 32'd72);
            step();
        end
        out_ready = 1'b1;
        g = 0;
        while (got_q.size() < 3 && g < 20) begin
            step();
            g++;
        end
        check("t4_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("t4_order0", got_q[0], 32'd72);
            check("t4_order1", got_q[1], 32'd16);
            check("t4_order2", got_q[2], 32'd32);
        end

        out_ready = 1'b0;
        send(fill(32'd1), 1'b1);
        send(fill(32'd5), 1'b0);
        send(fill(32'd5), 1'b0);
        in_valid = 1'b0;
        wait_out(2, "t5");
        check("t5_stalled", out_data, 32'd16);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        acc_m = '0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        send(fill(32'd2), 1'b1);
        in_valid = 1'b0;
        wait_out(4, "t5b");
        check("t5b_data", out_data, 32'd32);
        step();

        s_in_data  = {8'd1, 8'd100, 8'd200};
        s_in_last  = 1'b1;
        s_in_valid = 1'b1;
        check("t6_in_ready", 32'(s_in_ready), 32'd1);
        step();
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("t6_lat", 32'(lat), 32'd3);
        check("t6_data", 32'(s_out_data), 32'd45);
        step();

        s_in_data  = {8'd30, 8'd20, 8'd10};
        s_in_last  = 1'b0;
        s_in_valid = 1'b1;
        step();
        s_in_data  = {8'd255, 8'd255, 8'd255};
        s_in_last  = 1'b1;
        step();
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("t7_lat", 32'(lat), 32'd3);
        check("t7_data", 32'(s_out_data), 32'd57);
        step();
        check("t7_pulse", 32'(s_out_valid), 32'd0);

        repeat (3) step();
        check("model_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/array3d_reduce_pipe.md
Name: array3d_reduce_pipe

Overview:
- Parametrised, pipelined successor to the combinational 3-D array sum-and-double block.
- Takes a flattened D0×D1×D2 array of WIDTH-bit unsigned elements per beat and reduces it through a registered binary adder tree.
- Optionally accumulates several beats into one frame, then emits (sum << SHIFT) mod 2^WIDTH.
- Sits between an upstream array producer and a downstream consumer, with valid/ready handshakes on both sides.

Parameters:
- D0, 2, outer array dimension (≥1)
- D1, 2, middle array dimension (≥1)
- D2, 2, inner array dimension (≥1)
- WIDTH, 32, element and result width in bits (≥2)
- SHIFT, 1, left shift applied to the final sum; 0..WIDTH-1
- Derived, not overridable:
  - N = D0*D1*D2
  - P = next power of two ≥ N
  - L = log2(P), with L = 0 when N = 1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N*WIDTH  flattened array; element [i][j][k] occupies bits [((i*D1+j)*D2+k)*WIDTH +: WIDTH]
- in_last  in  1  beat closes the current frame
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  block accepts a beat this cycle
- out_data  out  WIDTH  frame result
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the result

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, accumulator=0, all stage valid bits 0. in_ready is 1 after reset because the output slot is empty.
- Global advance: en = !out_valid || out_ready; in_ready = en. A beat is accepted when in_valid && in_ready.
- When en=0, every pipeline register, the accumulator and the output hold. Bubbles are not collapsed.
- Tree:
  - Elements N..P-1 are padded with zero.
  - Level 0 registers pairwise sums of the padded inputs. Level m registers pairwise sums of level m-1.
  - Each level carries one valid bit and one last bit.
  - All additions are WIDTH bits, mod 2^WIDTH; carries are dropped.
  - When N=1 there is no tree level; the element feeds the final stage directly.
- Final stage, when en and the tree head is valid:
  - s = acc + tree_sum (mod 2^WIDTH).
  - If last: out_data <= (s << SHIFT) truncated to WIDTH; out_valid <= 1; acc <= 0.
  - Otherwise: acc <= s; out_valid <= 0.
  - When en and the tree head is not valid: out_valid <= 0 and acc holds.
- Latency: L+1 cycles from an accepted last beat to out_valid, with no stall. Throughput is one beat per cycle while out_ready=1.
- out_data and out_valid must stay stable while out_valid && !out_ready.
- A beat arriving while the final stage fires with last starts a fresh frame; it never merges with the closed frame.
- Non-last beats produce no output. Frame length is unbounded, and the accumulator wraps mod 2^WIDTH.
- Reset mid-frame discards all in-flight beats and the partial accumulation. No output is produced for them.
- in_data is ignored when in_valid=0. in_last is sampled only on acceptance.

Decomposition:
- Package array3d_reduce_pkg:
  - clog2 function
  - next-power-of-two function
  - default dimension constants
  - flattened-index function idx(i,j,k)
- Sub-module reduce_tree_level (parameters: IN_COUNT, WIDTH). It holds one registered pairwise-add level with valid/last bits and enable, and is instantiated L times via generate.
- The final accumulate/shift/output stage stays in the top module.

Test Plan:
- Defaults, single beat, elements [0][0][0]..[1][1][1] = 1..8, in_last=1, out_ready=1 -> out_valid exactly 4 cycles later, out_data=72, one cycle pulse.
- Defaults, all elements 0x8000_0001, last=1 -> sum wraps to 0x8, out_data=0x0000_0010.
- Defaults, three back-to-back beats of all 1s, last on third -> no out_valid for beats 1–2; single result 48; a following single beat of all 1s with last -> 16, with no residue from the previous frame.
- Backpressure: hold out_ready=0 once out_valid rises with 72 -> in_ready=0, out_data stays 72 and pipeline contents are preserved for 5 cycles. Raise out_ready -> 72 consumed once, queued beats emerge in order.
- Reset mid-frame: two non-last beats of all 5s, pulse rst_n low asynchronously (mid-cycle) -> out_valid=0 immediately. After release, one beat of all 2s with last -> 32.
- D0=3, D1=1, D2=1, WIDTH=8, SHIFT=0 (P=4, L=2): elements 200, 100, 1, last=1 -> out_data=45 (301 mod 256) three cycles after acceptance.
